// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider FSM states and the default mantissa width
// used by the multiplier, the divider and the FP divider top.
package fpu_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int N = 24
) (
  input  logic [N:0]   p_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   p_o,
  output logic         q_bit_o
);

  // One guard bit above P keeps the borrow visible even if the shifted
  // remainder reaches 2^N.
  logic [N+1:0] t;

  assign t       = {p_i, q_msb_i} - {2'b00, d_i};
  assign q_bit_o = ~t[N+1];
  assign p_o     = q_bit_o ? t[N:0] : {p_i[N-1:0], q_msb_i};

endmodule

// File: rtl/unsigned_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and the result side.
module unsigned_div
  import fpu_pkg::*;
#(
  parameter int N = MANT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t   state_q;
  logic [N:0]   p_q;
  logic [N-1:0] q_q;
  logic [N-1:0] d_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] quotient_q;
  logic [N-1:0] remainder_q;
  logic         dbz_q;

  logic [N:0]   p_nxt;
  logic         q_bit;

  div_step #(.N(N)) u_step (
    .p_i     (p_q),
    .q_msb_i (q_q[N-1]),
    .d_i     (d_q),
    .p_o     (p_nxt),
    .q_bit_o (q_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              p_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              // Divide-by-zero skips CALC and reports all-ones / dividend.
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CALC: begin
          p_q   <= p_nxt;
          q_q   <= {q_q[N-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quotient_q  <= {q_q[N-2:0], q_bit};
            remainder_q <= p_nxt[N-1:0];
            dbz_q       <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
